// File: rtl/rom_table_streamer.sv
// rom_table_streamer: sequences reads from the 512x16 table ROM
// and streams the words out on a valid/ready interface.
module rom_table_streamer #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_ad,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              rom_ce,
  output logic              rom_oce,
  output logic [ADDR_W-1:0] rom_ad,
  input  logic [DATA_W-1:0] rom_dout,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  issue_q, issue_d;
  logic [LEN_W-1:0]  out_q, out_d;
  logic              infl_q, infl_d;
  logic              done_q, done_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              wp_q, wp_d;
  logic              rp_q, rp_d;
  logic [DATA_W-1:0] mem_q [2];

  logic       pop;
  logic       push;
  logic       issue;
  logic [2:0] occ;
  logic       room;

  // Buffer occupancy after this cycle's pop, counting the read in flight.
  always_comb begin
    pop  = (cnt_q != 2'd0) & m_ready;
    push = infl_q;
    occ  = {1'b0, cnt_q} + {2'b0, infl_q} - {2'b0, pop};
    room = occ < 3'd2;
    issue = (state_q == RUN) & (issue_q != '0) & room
          & ~abort & ~reset;
  end

  // Next-state and counter updates; abort flushes everything.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    issue_d = issue_q;
    out_d   = out_q;
    infl_d  = issue;
    done_d  = 1'b0;
    cnt_d   = cnt_q + {1'b0, push} - {1'b0, pop};
    wp_d    = wp_q ^ push;
    rp_d    = rp_q ^ pop;

    if (issue) begin
      addr_d  = addr_q + 1'b1;
      issue_d = issue_q - 1'b1;
    end
    if (pop) begin
      out_d = out_q - 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = base_ad;
          issue_d = len;
          out_d   = len;
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (pop && m_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d = IDLE;
      addr_d  = '0;
      issue_d = '0;
      out_d   = '0;
      infl_d  = 1'b0;
      done_d  = 1'b0;
      cnt_d   = 2'd0;
      wp_d    = 1'b0;
      rp_d    = 1'b0;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      issue_q <= '0;
      out_q   <= '0;
      infl_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= 2'd0;
      wp_q    <= 1'b0;
      rp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      issue_q <= issue_d;
      out_q   <= out_d;
      infl_q  <= infl_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
    end
  end

  // Capture buffer storage; cleared on flush so idle data reads zero.
  always_ff @(posedge clk) begin
    if (reset || abort) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (push) begin
      mem_q[wp_q] <= rom_dout;
    end
  end

  // Output mapping.
  always_comb begin
    busy    = (state_q == RUN);
    done    = done_q;
    rom_ce  = issue;
    rom_oce = issue;
    rom_ad  = addr_q;
    m_valid = (cnt_q != 2'd0);
    m_data  = mem_q[rp_q];
    m_last  = (out_q == LEN_W'(1)) & m_valid;
  end

endmodule

// File: tb/tb_rom_table_streamer.sv
// tb_rom_table_streamer: directed checks of the ROM streamer
// against a behavioral ROM holding ROM[i] = i*3.
module tb_rom_table_streamer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [8:0]  base_ad;
  logic [9:0]  len;
  logic        busy;
  logic        done;
  logic        rom_ce;
  logic        rom_oce;
  logic [8:0]  rom_ad;
  logic [15:0] rom_dout;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;

  int total = 0;
  int bad   = 0;

  rom_table_streamer dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .abort   (abort),
    .base_ad (base_ad),
    .len     (len),
    .busy    (busy),
    .done    (done),
    .rom_ce  (rom_ce),
    .rom_oce (rom_oce),
    .rom_ad  (rom_ad),
    .rom_dout(rom_dout),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last)
  );

  always #5 clk = ~clk;

  function automatic int romv(input int a);
    return ((a % 512) * 3) & 16'hffff;
  endfunction

  always @(posedge clk) begin
    if (rom_ce) rom_dout <= 16'(romv(int'(rom_ad)));
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Move to the next cycle: inputs change just after the edge.
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic run_full(input int b, input int n);
    int ces;
    cyc();
    start = 1'b1; base_ad = 9'(b); len = 10'(n); m_ready = 1'b1;
    @(negedge clk);
    chk("c0_ce", rom_ce, 0);
    ces = 0;
    for (int c = 1; c <= n + 3; c++) begin
      cyc();
      start = 1'b0;
      @(negedge clk);
      chk("ce", rom_ce, (c <= n) ? 1 : 0);
      chk("oce", rom_oce, rom_ce);
      if (rom_ce) begin
        chk("ad", rom_ad, (b + ces) % 512);
        ces++;
      end
      chk("valid", m_valid, (c >= 3 && c <= n + 2) ? 1 : 0);
      if (c >= 3 && c <= n + 2) begin
        chk("data", m_data, romv(b + c - 3));
        chk("last", m_last, (c == n + 2) ? 1 : 0);
      end
      chk("done", done, (c == n + 3) ? 1 : 0);
      chk("busy", busy, (c < n + 3) ? 1 : 0);
    end
    chk("ce_cnt", ces, n);
  endtask

  initial begin : main
    logic [7:0]  lfsr;
    logic [15:0] prev_data;
    int cnt, idx, got_done, prev_stall, infl, pop, cyc_n;

    reset = 1'b1; start = 1'b0; abort = 1'b0;
    base_ad = '0; len = '0; m_ready = 1'b0;
    repeat (2) cyc();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ce", rom_ce, 0);
    chk("rst_oce", rom_oce, 0);
    chk("rst_ad", rom_ad, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_last", m_last, 0);
    chk("rst_data", m_data, 0);
    cyc();
    reset = 1'b0;

    // Basic stream and address wrap.
    run_full(5, 4);
    run_full(510, 4);

    // Zero length, then a start in the done cycle.
    cyc();
    start = 1'b1; base_ad = 9'd0; len = 10'd0;
    @(negedge clk);
    chk("z_ce0", rom_ce, 0);
    cyc();
    start = 1'b1; base_ad = 9'd20; len = 10'd1;
    @(negedge clk);
    chk("z_done", done, 1);
    chk("z_busy", busy, 0);
    chk("z_ce1", rom_ce, 0);
    chk("z_valid", m_valid, 0);
    cyc();
    start = 1'b0;
    @(negedge clk);
    chk("bb_busy", busy, 1);
    chk("bb_ce", rom_ce, 1);
    chk("bb_ad", rom_ad, 20);
    got_done = 0;
    for (int c = 0; c < 10 && got_done == 0; c++) begin
      cyc();
      @(negedge clk);
      if (m_valid) chk("bb_data", m_data, romv(20));
      if (done) got_done = 1;
    end
    chk("bb_fin", got_done, 1);

    // Backpressure with an LFSR-driven ready.
    cyc();
    start = 1'b1; base_ad = 9'd100; len = 10'd8; m_ready = 1'b0;
    lfsr = 8'hA5;
    @(negedge clk);
    cnt = 0; infl = 0; idx = 0; got_done = 0; prev_stall = 0;
    prev_data = '0;
    cyc_n = 0;
    while (got_done == 0 && cyc_n < 300) begin
      cyc_n++;
      cyc();
      start = 1'b0;
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      m_ready = lfsr[0];
      @(negedge clk);
      if (prev_stall != 0) chk("bp_hold", m_data, prev_data);
      chk("bp_valid", m_valid, (cnt > 0) ? 1 : 0);
      pop = (m_valid && m_ready) ? 1 : 0;
      if (rom_ce) chk("bp_ovf", (cnt + infl - pop < 2) ? 1 : 0, 1);
      if (pop != 0) begin
        chk("bp_data", m_data, romv(100 + idx));
        chk("bp_last", m_last, (idx == 7) ? 1 : 0);
        idx++;
      end
      if (done) got_done = 1;
      prev_stall = (m_valid && !m_ready) ? 1 : 0;
      prev_data = m_data;
      cnt = cnt + infl - pop;
      infl = rom_ce ? 1 : 0;
    end
    chk("bp_words", idx, 8);
    chk("bp_fin", got_done, 1);

    // Abort under backpressure.
    cyc();
    start = 1'b1; base_ad = 9'd0; len = 10'd10; m_ready = 1'b1;
    cyc(); start = 1'b0;
    cyc();
    cyc(); m_ready = 1'b0;
    @(negedge clk);
    chk("ab_v3", m_valid, 1);
    cyc(); abort = 1'b1;
    cyc(); abort = 1'b0;
    @(negedge clk);
    chk("ab_busy", busy, 0);
    chk("ab_valid", m_valid, 0);
    chk("ab_ce", rom_ce, 0);
    chk("ab_done5", done, 0);
    cyc();
    @(negedge clk);
    chk("ab_done6", done, 0);
    run_full(0, 1);

    // Reset mid-transfer; start ignored while reset is high.
    cyc();
    start = 1'b1; base_ad = 9'd50; len = 10'd6; m_ready = 1'b1;
    cyc(); start = 1'b0;
    cyc();
    cyc();
    cyc(); reset = 1'b1; start = 1'b1;
    cyc();
    @(negedge clk);
    chk("mr_busy", busy, 0);
    chk("mr_ce", rom_ce, 0);
    chk("mr_ad", rom_ad, 0);
    chk("mr_valid", m_valid, 0);
    chk("mr_last", m_last, 0);
    chk("mr_data", m_data, 0);
    chk("mr_done", done, 0);
    cyc(); reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("mr_ign", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/rom_table_streamer.md
# rom_table_streamer

Sequencing stage directly upstream of the 512x16 single-port table ROM (bypass read mode, 1-cycle read latency). On a start command it issues sequential ROM reads from a base address for a programmed word count and delivers the words on a valid/ready stream with full backpressure support. A 2-entry capture buffer absorbs the ROM latency, so the ROM is never read ahead of available buffer space.

## Interface
- ADDR_W, 9, ROM address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 16, ROM/stream data width.
- LEN_W, 10, width of the word-count input.

Ports:
- clk  in  1  single clock for the block and the ROM.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- start  in  1  command pulse; sampled only in IDLE.
- abort  in  1  cancels a running transfer; no done pulse.
- base_ad  in  ADDR_W  first ROM address, sampled with start.
- len  in  LEN_W  number of words, sampled with start; 0 is legal.
- busy  out  1  high while a transfer is in progress.
- done  out  1  one-cycle pulse at normal completion.
- rom_ce  out  1  ROM read enable.
- rom_oce  out  1  ROM output clock enable; always equal to rom_ce.
- rom_ad  out  ADDR_W  ROM read address, registered.
- rom_dout  in  DATA_W  ROM data, valid in the cycle after rom_ce.
- m_data  out  DATA_W  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready from the consumer.
- m_last  out  1  marks the final word of the transfer.

## Operation
- States: IDLE, RUN.
- IDLE: busy=0 and rom_ce=0. When start=1 and abort=0, load addr=base_ad, issue_left=len, out_left=len.
  - len=0: stay in IDLE and pulse done next cycle.
  - Otherwise: go to RUN.
- Issue rule in RUN: rom_ce=1 iff issue_left>0 and (buf_count + inflight − pop) < 2. pop = m_valid & m_ready in the current cycle. inflight = rom_ce of the previous cycle.
- On issue:
  - rom_ad = addr; addr then increments modulo 2^ADDR_W (511→0), and issue_left decrements.
  - Counts above 512 re-read the wrapped addresses.
- Capture: when inflight=1, rom_dout is written into the 2-entry FIFO. A simultaneous push and pop is legal, and the count stays unchanged.
- Output:
  - m_valid = buf_count>0; m_data = FIFO head.
  - m_last = (out_left==1) & m_valid.
  - A handshake decrements out_left.
  - m_data must be held stable while m_valid=1 and m_ready=0.
- Completion: the handshake with m_last=1 → next cycle is IDLE, busy=0, done=1 for one cycle.
- abort=1 in any state: next cycle is IDLE. The FIFO is flushed, counters are cleared, and there is no done pulse. Any in-flight ROM data is discarded. abort has priority over start in the same cycle.
- start while busy: ignored.
- reset: same as abort, and additionally all outputs take their reset values.

## Timing
- Reset values: busy=0, done=0, rom_ce=0, rom_oce=0, rom_ad=0, m_valid=0, m_last=0, m_data=0.
- start in cycle 0 → busy=1 and first rom_ce in cycle 1 → rom_dout valid in cycle 2 → m_valid in cycle 3.
- With m_ready held high: one word per cycle. The last handshake occurs in cycle len+2, done pulses in cycle len+3, and busy is 0 in cycle len+3.
- Backpressure: at most 2 words are buffered plus 0 in flight, or 1 buffered plus 1 in flight. rom_ce must never fire when that would overflow the FIFO.
- When m_ready rises after a stall, reads resume so that throughput returns to one word per cycle within 1 cycle.
- A new start is accepted in the same cycle done is high (IDLE).

## Test plan
- ROM[i]=i*3 (mod 2^16), base_ad=5, len=4, m_ready=1:
  - m_data 15,18,21,24 in cycles 3–6; m_last only on 24.
  - done in cycle 7; exactly 4 rom_ce pulses.
- Wrap: base_ad=510, len=4 → rom_ad 510,511,0,1, and data in that order.
- Backpressure: len=8 with m_ready toggled by an LFSR:
  - All 8 words arrive in order with no duplicates or losses.
  - The FIFO count never exceeds 2, and m_data stays stable during stalls.
- len=0 → done in cycle 1; rom_ce and m_valid never assert.
- Abort in cycle 4 of a len=10 transfer, with m_ready=0 from cycle 3: IDLE in cycle 5, m_valid=0, no done. A following start with base_ad=0, len=1 completes normally.
- Reset asserted mid-transfer: all outputs are at their reset values in the next cycle, and start is ignored while reset=1.
